// File: rtl/hilo_div_ctrl_pkg.sv
// Shared constants for the HI/LO divide sequencer: FSM state encoding and
// handshake levels.
package hilo_div_ctrl_pkg;

  localparam int RegBus = 32;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic WriteEnable = 1'b1;
  localparam logic RstEnable = 1'b1;

  localparam logic DivResultReady = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;

  typedef enum logic [1:0] {
    DivIdle  = 2'd0,
    DivShort = 2'd1,
    DivRun   = 2'd2,
    DivDone  = 2'd3
  } div_state_t;

endpackage

// File: rtl/hilo_div_ctrl_step.sv
// One restoring-divide iteration: shift in a dividend bit, trial-subtract
// the divisor, keep the difference when it is non-negative.
module hilo_div_ctrl_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, dividend_bit};
  assign diff    = shifted - {1'b0, divisor};

  // A negative difference means shifted < divisor, so it fits in WIDTH bits.
  always_comb begin
    q_bit    = ~diff[WIDTH];
    rem_next = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  end

endmodule

// File: rtl/hilo_div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer producing the HI (remainder) / LO (quotient)
// write pair. Optional HILO_DIV_EARLY_EXIT_EN skips RUN when |dividend| < |divisor|.
module hilo_div_ctrl
  import hilo_div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             annul_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             ready_o,
  output logic             stallreq_o
);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  div_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] dividend_reg, dividend_next;
  logic [WIDTH-1:0] divisor_reg, divisor_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next;
  logic [WIDTH-1:0] short_hi_reg, short_hi_next;
  logic             signed_reg, signed_next;
  logic             dividend_neg_reg, dividend_neg_next;
  logic             divisor_neg_reg, divisor_neg_next;

  logic             dividend_neg, divisor_neg;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH-1:0] step_rem, quot_final;
  logic             step_q;
  logic             abort;

  assign dividend_neg = signed_i & dividend_i[WIDTH-1];
  assign divisor_neg  = signed_i & divisor_i[WIDTH-1];
  assign dividend_mag = magnitude(dividend_i, dividend_neg);
  assign divisor_mag  = magnitude(divisor_i, divisor_neg);
  assign abort        = annul_i | ~start_i;

  // Quotient bits shift into the dividend register as its bits are consumed.
  hilo_div_ctrl_step #(.WIDTH(WIDTH)) u_step (
    .rem          (rem_reg),
    .dividend_bit (dividend_reg[WIDTH-1]),
    .divisor      (divisor_reg),
    .rem_next     (step_rem),
    .q_bit        (step_q)
  );

  assign quot_final = {dividend_reg[WIDTH-2:0], step_q};

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    dividend_next     = dividend_reg;
    divisor_next      = divisor_reg;
    rem_next          = rem_reg;
    hi_next           = hi_reg;
    lo_next           = lo_reg;
    short_hi_next     = short_hi_reg;
    signed_next       = signed_reg;
    dividend_neg_next = dividend_neg_reg;
    divisor_neg_next  = divisor_neg_reg;
    case (state_reg)
      DivIdle: begin
        if (start_i == DivStart && !annul_i) begin
          signed_next       = signed_i;
          dividend_neg_next = dividend_neg;
          divisor_neg_next  = divisor_neg;
          dividend_next     = dividend_mag;
          divisor_next      = divisor_mag;
          cnt_next          = '0;
          rem_next          = '0;
          if (divisor_i == '0) begin
            short_hi_next = '0;
            state_next    = DivShort;
`ifdef HILO_DIV_EARLY_EXIT_EN
          end else if (dividend_mag < divisor_mag) begin
            short_hi_next = dividend_i;
            state_next    = DivShort;
`endif
          end else begin
            state_next = DivRun;
          end
        end
      end
      DivShort: begin
        if (abort) begin
          state_next = DivIdle;
        end else begin
          hi_next    = short_hi_reg;
          lo_next    = '0;
          state_next = DivDone;
        end
      end
      DivRun: begin
        if (abort) begin
          state_next = DivIdle;
        end else begin
          rem_next      = step_rem;
          dividend_next = quot_final;
          cnt_next      = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            // Sign fix wraps mod 2^WIDTH, so MIN / -1 yields MIN with no trap.
            lo_next    = magnitude(quot_final, signed_reg & (dividend_neg_reg ^ divisor_neg_reg));
            hi_next    = magnitude(step_rem, signed_reg & dividend_neg_reg);
            state_next = DivDone;
          end
        end
      end
      default: state_next = DivIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_reg        <= DivIdle;
      cnt_reg          <= '0;
      dividend_reg     <= '0;
      divisor_reg      <= '0;
      rem_reg          <= '0;
      hi_reg           <= '0;
      lo_reg           <= '0;
      short_hi_reg     <= '0;
      signed_reg       <= 1'b0;
      dividend_neg_reg <= 1'b0;
      divisor_neg_reg  <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      dividend_reg     <= dividend_next;
      divisor_reg      <= divisor_next;
      rem_reg          <= rem_next;
      hi_reg           <= hi_next;
      lo_reg           <= lo_next;
      short_hi_reg     <= short_hi_next;
      signed_reg       <= signed_next;
      dividend_neg_reg <= dividend_neg_next;
      divisor_neg_reg  <= divisor_neg_next;
    end
  end

  assign ready_o    = (state_reg == DivDone) ? DivResultReady : DivResultNotReady;
  assign hi_o       = hi_reg;
  assign lo_o       = lo_reg;
  assign stallreq_o = start_i & ~ready_o & ~annul_i;

endmodule

// File: doc/hilo_div_ctrl.md
Name: hilo_div_ctrl

Overview:
- Multi-cycle divide sequencer for DIV/DIVU in the EX stage.
- Runs a radix-2 restoring divide, one quotient bit per cycle.
- Holds a pipeline stall while the divide runs.
- Delivers remainder/quotient as the HI/LO write data pair; the pipeline forwards it to the HI/LO register write port with write-enable = ready_o.

Parameters:
- WIDTH, 32, operand and result width (RegBus width).
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start_i  input  1  divide requested by the instruction currently in EX
- annul_i  input  1  flush; cancels the in-flight divide
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU
- dividend_i  input  WIDTH  rs operand
- divisor_i  input  WIDTH  rt operand
- hi_o  output  WIDTH  remainder, valid when ready_o
- lo_o  output  WIDTH  quotient, valid when ready_o
- ready_o  output  1  one-cycle result-valid pulse, used as the HI/LO write enable
- stallreq_o  output  1  pipeline stall request

Behaviour:
- Reset: state IDLE, ready_o=0, hi_o=0, lo_o=0, counter=0, internal dividend/divisor/partial remainder=0.
- States: IDLE, SHORT, RUN, DONE. The state is registered.
- stallreq_o is combinational: start_i & ~ready_o & ~annul_i.
- IDLE, when start_i=1 and annul_i=0:
  - Latch signed_i and both operand signs.
  - If signed_i, latch operand magnitudes; otherwise latch raw operands.
  - If divisor_i==0, go to SHORT with result quotient=0, remainder=0.
  - Otherwise go to RUN with counter=0 and partial remainder=0.
- IDLE with start_i=1 and annul_i=1: request ignored, stay in IDLE.
- RUN, each cycle:
  - Shift the partial remainder left by one, bringing in the next dividend MSB.
  - Trial subtract the divisor, using a WIDTH+1-bit difference.
  - If the difference is non-negative, keep it and set the quotient bit to 1; otherwise set the quotient bit to 0.
  - counter++.
  - When counter reaches WIDTH, go to DONE.
- Sign fix on entering DONE (signed only):
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Arithmetic is mod 2^WIDTH, so 0x80000000 / -1 gives quotient 0x80000000, remainder 0, with no trap.
- SHORT: loads the prepared result and goes to DONE next cycle.
- DONE: ready_o=1 for exactly this cycle, hi_o/lo_o valid. Next state is always IDLE. hi_o/lo_o hold their value until the next completion.
- Latency, counting the accepting cycle as cycle 0:
  - Normal divide: RUN cycles 1..WIDTH, ready_o at cycle WIDTH+1 (33).
  - Divide-by-zero: ready_o at cycle 2.
- Back-to-back: if start_i is still high in the IDLE cycle after DONE, a new divide is accepted. stallreq_o is low during the DONE cycle, so the pipeline advances.
- Abort: annul_i=1, or start_i=0, while in SHORT or RUN returns to IDLE next cycle. ready_o stays 0, hi_o/lo_o are unchanged, and no HI/LO write occurs.
- annul_i during DONE: ready_o still pulses; the pipeline's flush suppresses the write.
- Operands are sampled only in IDLE. Input changes during RUN are ignored.

Optional Feature:
- Macro: HILO_DIV_EARLY_EXIT_EN.
- Defined:
  - In IDLE with a nonzero divisor, if the latched magnitude of the dividend is less than the latched magnitude of the divisor (unsigned compare), go to SHORT.
  - Result is quotient=0, remainder=original dividend_i, with sign preserved.
  - ready_o at cycle 2.
- Undefined: these cases take the full RUN path. Results are identical, ready_o at cycle 33.

Decomposition:
- Shared package/header (de.v):
  - Add constants DivIdle, DivShort, DivRun, DivDone (2-bit).
  - Add DivResultReady/DivResultNotReady and DivStart/DivStop.
  - Reuse RegBus, ZeroWord, WriteEnable, RstEnable.
- One sub-module is natural: div_step, a combinational single-iteration shift/trial-subtract returning the next partial remainder and the quotient bit. The FSM, counter and sign fix stay in hilo_div_ctrl.

Test Plan:
- DIVU 100/7, start held high -> stallreq_o=1 for cycles 0..32; ready_o=1 only at cycle 33; lo_o=14, hi_o=2; stallreq_o=0 at cycle 33.
- DIV -7/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIVU 5/0 -> ready_o at cycle 2, hi_o=0, lo_o=0.
- DIVU 1000/3, annul_i pulsed at cycle 10 -> IDLE at cycle 11, ready_o never asserts, hi_o/lo_o keep the prior result. A fresh DIVU 9/4 then yields lo_o=2, hi_o=1 at its cycle 33.
- Two back-to-back DIVUs (20/6, then 7/7) with start_i held -> two ready_o pulses 34 cycles apart: first lo_o=3, hi_o=2; second lo_o=1, hi_o=0.
- DIV -5/9:
  - With HILO_DIV_EARLY_EXIT_EN: ready_o at cycle 2, lo_o=0, hi_o=0xFFFFFFFB.
  - Without the macro: same values at cycle 33.
  - Reset asserted mid-RUN: next cycle IDLE, all outputs 0.
